// File: rtl/sky_capture.sv
// sky_capture: decodes the sky renderer's x/y/color/plot pixel stream back
// into four column occupancy words, publishing them once per frame.
// Each cell keeps a seen mask and a lit mask over its pixels. At commit, a
// cell is meatball (2'b10) only when it was fully drawn and fully lit, and
// empty (2'b00) otherwise. A partly drawn or mixed cell is also flagged.
module sky_capture #(
  parameter int CELL_W = 4,
  parameter int CELL_H = 4,
  parameter int ROWS   = 14,
  parameter int COLS   = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              plot,
  input  logic [7:0]        x,
  input  logic [6:0]        y,
  input  logic [2:0]        color,
  input  logic              frame_done,
  output logic [2*ROWS-1:0] col1,
  output logic [2*ROWS-1:0] col2,
  output logic [2*ROWS-1:0] col3,
  output logic [2*ROWS-1:0] col4,
  output logic              frame_valid,
  output logic              cell_error,
  output logic              oob_seen,
  output logic              busy
);

  localparam int NCELLS  = COLS * ROWS;
  localparam int PIX     = CELL_W * CELL_H;
  localparam int CELL_AW = $clog2(NCELLS);
  localparam int PIX_AW  = $clog2(PIX);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    COMMIT  = 2'd2
  } state_t;

  state_t state_r, state_nxt_s;

  logic [PIX-1:0]     seen_r [NCELLS];
  logic [PIX-1:0]     lit_r  [NCELLS];
  logic               oob_r;

  logic [2*ROWS-1:0]  col_r      [COLS];
  logic [2*ROWS-1:0]  col_word_s [COLS];
  logic               frame_valid_r;
  logic               cell_error_r;
  logic               oob_seen_r;
  logic               decode_err_s;

  logic [7:0]         col_s;
  logic [6:0]         row_s;
  logic [7:0]         pix_s;
  logic [7:0]         cell_s;
  logic               in_range_s;
  logic [CELL_AW-1:0] cell_idx_s;
  logic [PIX_AW-1:0]  pix_idx_s;
  logic               lit_s;

  logic               clr_s;
  logic               wr_s;
  logic               oob_set_s;
  logic               commit_s;

  // Returns {error, code} for one cell from its seen and lit masks.
  function automatic logic [2:0] decode_cell(input logic [PIX-1:0] seen,
                                             input logic [PIX-1:0] lit);
    logic [2:0] res;
    if (&seen) begin
      if (&lit) begin
        res = {1'b0, 2'b10};
      end else if (lit == '0) begin
        res = {1'b0, 2'b00};
      end else begin
        res = {1'b1, 2'b00};
      end
    end else begin
      res = {1'b1, 2'b00};
    end
    return res;
  endfunction

  // Map the incoming pixel to a cell and a pixel position inside that cell.
  always_comb begin
    col_s      = x / 8'(CELL_W);
    row_s      = y / 7'(CELL_H);
    pix_s      = 8'(y % 7'(CELL_H)) * 8'(CELL_W) + (x % 8'(CELL_W));
    cell_s     = col_s * 8'(ROWS) + {1'b0, row_s};
    in_range_s = (x < 8'(COLS * CELL_W)) && (y < 7'(ROWS * CELL_H));
    cell_idx_s = CELL_AW'(cell_s);
    pix_idx_s  = PIX_AW'(pix_s);
    lit_s      = (color != 3'b000);
  end

  // Next-state logic and the per-cycle mask/flag controls.
  always_comb begin
    state_nxt_s = state_r;
    clr_s       = 1'b0;
    wr_s        = 1'b0;
    oob_set_s   = 1'b0;
    commit_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (plot) begin
          // First pixel of a frame: wipe the old frame and keep this pixel.
          state_nxt_s = CAPTURE;
          clr_s       = 1'b1;
          wr_s        = in_range_s;
          oob_set_s   = !in_range_s;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CAPTURE: begin
        wr_s      = plot && in_range_s;
        oob_set_s = plot && !in_range_s;
        if (frame_done) begin
          state_nxt_s = COMMIT;
        end else begin
          state_nxt_s = CAPTURE;
        end
      end
      COMMIT: begin
        // Pixels arriving here are dropped; the renderer is idle.
        commit_s    = 1'b1;
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Working masks: whole-frame clear, then the current pixel (same edge).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < NCELLS; c++) begin
        seen_r[c] <= '0;
        lit_r[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < NCELLS; c++) begin
        if (clr_s) begin
          seen_r[c] <= '0;
          lit_r[c]  <= '0;
        end
        if (wr_s && (cell_idx_s == CELL_AW'(c))) begin
          seen_r[c][pix_idx_s] <= 1'b1;
          lit_r[c][pix_idx_s]  <= lit_s;
        end
      end
    end
  end

  // Out-of-range flag for the frame being captured.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      oob_r <= 1'b0;
    end else if (clr_s) begin
      oob_r <= oob_set_s;
    end else if (oob_set_s) begin
      oob_r <= 1'b1;
    end
  end

  // Decode every cell of the working masks into column words.
  always_comb begin
    decode_err_s = 1'b0;
    for (int c = 0; c < COLS; c++) begin
      col_word_s[c] = '0;
      for (int r = 0; r < ROWS; r++) begin
        logic [2:0] d;
        d = decode_cell(seen_r[CELL_AW'(c * ROWS + r)],
                        lit_r[CELL_AW'(c * ROWS + r)]);
        col_word_s[c][2*r +: 2] = d[1:0];
        decode_err_s            = decode_err_s | d[2];
      end
    end
  end

  // Published outputs: loaded on the edge leaving COMMIT, held otherwise.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < COLS; c++) begin
        col_r[c] <= '0;
      end
      frame_valid_r <= 1'b0;
      cell_error_r  <= 1'b0;
      oob_seen_r    <= 1'b0;
    end else if (commit_s) begin
      for (int c = 0; c < COLS; c++) begin
        col_r[c] <= col_word_s[c];
      end
      frame_valid_r <= 1'b1;
      cell_error_r  <= decode_err_s;
      oob_seen_r    <= oob_r;
    end else begin
      frame_valid_r <= 1'b0;
    end
  end

  assign col1        = col_r[0];
  assign col2        = col_r[1];
  assign col3        = col_r[2];
  assign col4        = col_r[3];
  assign frame_valid = frame_valid_r;
  assign cell_error  = cell_error_r;
  assign oob_seen    = oob_seen_r;
  assign busy        = (state_r != IDLE);

endmodule

// File: tb/tb_sky_capture.sv
// tb_sky_capture: directed frames through sky_capture, checked against
// hand-computed column words, flags and commit timing.
module tb_sky_capture;

  logic        clock;
  logic        reset;
  logic        plot;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  color;
  logic        frame_done;
  logic [27:0] col1, col2, col3, col4;
  logic        frame_valid, cell_error, oob_seen, busy;

  int errors = 0;
  int checks = 0;

  // Lit cells of the frame to draw, one 14-bit row map per column.
  bit [13:0] lit_map [4];
  int skip_x, skip_y, dark_x, dark_y;
  bit inject_oob;
  int pulses, first_pulse;

  sky_capture dut (
    .clock       (clock),
    .reset       (reset),
    .plot        (plot),
    .x           (x),
    .y           (y),
    .color       (color),
    .frame_done  (frame_done),
    .col1        (col1),
    .col2        (col2),
    .col3        (col3),
    .col4        (col4),
    .frame_valid (frame_valid),
    .cell_error  (cell_error),
    .oob_seen    (oob_seen),
    .busy        (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Global time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_px(input int px, input int py, input logic [2:0] pc);
    @(negedge clock);
    plot  = 1'b1;
    x     = 8'(px);
    y     = 7'(py);
    color = pc;
  endtask

  task automatic clear_pattern();
    for (int c = 0; c < 4; c++) lit_map[c] = 14'h0;
    skip_x = -1; skip_y = -1; dark_x = -1; dark_y = -1;
    inject_oob = 1'b0;
  endtask

  // Full 16x56 raster; optionally leaves out (15,55) for end_frame to send.
  task automatic draw_raster(input bit skip_last);
    for (int yi = 0; yi < 56; yi++) begin
      for (int xi = 0; xi < 16; xi++) begin
        logic [2:0] c;
        if (!(skip_last && xi == 15 && yi == 55) && !(xi == skip_x && yi == skip_y)) begin
          c = lit_map[xi / 4][yi / 4] ? 3'b111 : 3'b000;
          if (xi == dark_x && yi == dark_y) c = 3'b000;
          send_px(xi, yi, c);
        end
      end
    end
    if (inject_oob) begin
      send_px(16, 0, 3'b000);
      send_px(0, 56, 3'b000);
    end
  endtask

  // Raise frame_done for 'hold' cycles and record frame_valid pulses.
  task automatic end_frame(input int hold, input bit with_last);
    @(negedge clock);
    if (with_last) begin
      plot  = 1'b1;
      x     = 8'd15;
      y     = 7'd55;
      color = lit_map[3][13] ? 3'b111 : 3'b000;
    end else begin
      plot = 1'b0;
    end
    frame_done  = 1'b1;
    pulses      = 0;
    first_pulse = -1;
    for (int i = 1; i <= hold + 4; i++) begin
      @(negedge clock);
      if (frame_valid) begin
        pulses++;
        if (first_pulse < 0) first_pulse = i;
      end
      plot = 1'b0;
      if (i >= hold) frame_done = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b0; plot = 1'b0; x = 8'd0; y = 7'd0; color = 3'd0; frame_done = 1'b0;
    clear_pattern();
    repeat (2) @(negedge clock);
    check("rst_col1", 32'(col1), 32'h0);
    check("rst_col4", 32'(col4), 32'h0);
    check("rst_fv", 32'(frame_valid), 32'h0);
    check("rst_err", 32'(cell_error), 32'h0);
    check("rst_oob", 32'(oob_seen), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    reset = 1'b1;

    // Partial all-lit frame, then reset in the middle of it.
    for (int c = 0; c < 4; c++) lit_map[c] = 14'h3fff;
    for (int i = 0; i < 100; i++) send_px(i % 16, i / 16, 3'b111);
    @(negedge clock);
    check("cap_busy", 32'(busy), 32'h1);
    #2 reset = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_col1", 32'(col1), 32'h0);
    @(negedge clock);
    reset = 1'b1; plot = 1'b0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (frame_valid) pulses++;
    end
    check("midrst_nofv", 32'(pulses), 32'h0);
    check("midrst_col3", 32'(col3), 32'h0);

    // Empty sky.
    clear_pattern();
    draw_raster(1'b0);
    end_frame(1, 1'b0);
    check("empty_pulses", 32'(pulses), 32'h1);
    check("empty_lat", 32'(first_pulse), 32'h2);
    check("empty_col1", 32'(col1), 32'h0);
    check("empty_col2", 32'(col2), 32'h0);
    check("empty_col3", 32'(col3), 32'h0);
    check("empty_col4", 32'(col4), 32'h0);
    check("empty_err", 32'(cell_error), 32'h0);
    check("empty_oob", 32'(oob_seen), 32'h0);
    check("empty_busy", 32'(busy), 32'h0);

    // Single meatball: column 3, row 5.
    clear_pattern();
    lit_map[2] = 14'h0020;
    draw_raster(1'b0);
    end_frame(1, 1'b0);
    check("ball_col1", 32'(col1), 32'h0);
    check("ball_col2", 32'(col2), 32'h0);
    check("ball_col3", 32'(col3), 32'h0000800);
    check("ball_col4", 32'(col4), 32'h0);
    check("ball_err", 32'(cell_error), 32'h0);

    // Mixed cell (col1 row0 with a dark pixel), incomplete cell (col4 row13).
    clear_pattern();
    lit_map[0] = 14'h0001;
    lit_map[1] = 14'h0008;
    lit_map[3] = 14'h2000;
    dark_x = 0; dark_y = 0;
    skip_x = 13; skip_y = 53;
    draw_raster(1'b0);
    end_frame(1, 1'b0);
    check("mix_col1", 32'(col1), 32'h0);
    check("mix_col2", 32'(col2), 32'h0000080);
    check("mix_col4", 32'(col4), 32'h0);
    check("mix_err", 32'(cell_error), 32'h1);

    // Out-of-range pixels plus last pixel together with frame_done.
    clear_pattern();
    lit_map[1] = 14'h2001;
    lit_map[3] = 14'h2000;
    inject_oob = 1'b1;
    draw_raster(1'b1);
    end_frame(1, 1'b1);
    check("oob_flag", 32'(oob_seen), 32'h1);
    check("oob_col1", 32'(col1), 32'h0);
    check("oob_col2", 32'(col2), 32'h8000002);
    check("oob_col4", 32'(col4), 32'h8000000);
    check("oob_err", 32'(cell_error), 32'h0);
    check("oob_lat", 32'(first_pulse), 32'h2);

    // Everything lit, frame_done held for 5 cycles.
    clear_pattern();
    for (int c = 0; c < 4; c++) lit_map[c] = 14'h3fff;
    draw_raster(1'b0);
    end_frame(5, 1'b0);
    check("hold_pulses", 32'(pulses), 32'h1);
    check("full_col1", 32'(col1), 32'haaaaaaa);
    check("full_col4", 32'(col4), 32'haaaaaaa);
    check("full_oob", 32'(oob_seen), 32'h0);
    check("hold_busy", 32'(busy), 32'h0);

    // Back-to-back: only col1 row1 lit; nothing stale may remain.
    clear_pattern();
    lit_map[0] = 14'h0002;
    draw_raster(1'b0);
    end_frame(1, 1'b0);
    check("b2b_col1", 32'(col1), 32'h0000008);
    check("b2b_col2", 32'(col2), 32'h0);
    check("b2b_col3", 32'(col3), 32'h0);
    check("b2b_col4", 32'(col4), 32'h0);
    check("b2b_err", 32'(cell_error), 32'h0);

    // Outputs hold between commits.
    repeat (5) @(negedge clock);
    check("hold_col1", 32'(col1), 32'h0000008);
    check("idle_fv", 32'(frame_valid), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
